// File: rtl/fpu_mul_pipe.sv
// Three-stage IEEE-754 multiplier (flush-to-zero, RNE) with valid/ready backpressure.
// Feeds FFT butterfly adders from the twiddle/sample registers.
module fpu_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int SIZE_DATA = 1 + EXP_W + MAN_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_32_a,
    input  logic [SIZE_DATA-1:0] i_32_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_32_mul,
    output logic [3:0]           o_flags
);

    localparam int EXW = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic signed [EXW-1:0] C_BIAS = EXW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EXW-1:0] C_EMAX = EXW'((1 << EXP_W) - 1);
    localparam logic signed [EXW-1:0] C_ZERO = '0;
    localparam logic [SIZE_DATA-1:0] C_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    // Rounded significand; it wraps to zero when the hidden bit carries out.
    function automatic logic [MAN_W:0] f_rne(input logic [MAN_W:0] kept,
                                             input logic guard, input logic sticky);
        logic inc;
        inc = guard & (sticky | kept[0]);
        return kept + {{MAN_W{1'b0}}, inc};
    endfunction

    // Returns {flags, packed result}, applying overflow-to-Inf and flush-to-zero.
    function automatic logic [SIZE_DATA+3:0] f_pack(input logic sign,
                                                    input logic signed [EXW-1:0] e,
                                                    input logic [MAN_W-1:0] frac,
                                                    input logic inexact);
        if (e >= C_EMAX)
            return {4'b0101, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e <= C_ZERO)
            return {4'b0011, sign, {(EXP_W + MAN_W){1'b0}}};
        else
            return {3'b000, inexact, sign, e[EXP_W-1:0], frac};
    endfunction

    logic w_stall;
    logic w_adv;
    assign w_stall = o_valid & ~i_ready;
    assign w_adv   = ~w_stall;
    assign o_ready = w_adv;

    logic             w_a_sign, w_b_sign;
    logic [EXP_W-1:0] w_a_exp,  w_b_exp;
    logic [MAN_W-1:0] w_a_frac, w_b_frac;
    logic w_a_zero, w_a_inf, w_a_nan, w_a_snan;
    logic w_b_zero, w_b_inf, w_b_nan, w_b_snan;
    logic                  w_sign;
    logic signed [EXW-1:0] w_exp_sum;
    logic                  w_spec;
    logic [SIZE_DATA-1:0]  w_spec_res;
    logic [3:0]            w_spec_flg;

    assign w_a_sign = i_32_a[SIZE_DATA-1];
    assign w_b_sign = i_32_b[SIZE_DATA-1];
    assign w_a_exp  = i_32_a[SIZE_DATA-2 -: EXP_W];
    assign w_b_exp  = i_32_b[SIZE_DATA-2 -: EXP_W];
    assign w_a_frac = i_32_a[MAN_W-1:0];
    assign w_b_frac = i_32_b[MAN_W-1:0];

    // Subnormal inputs fall into the zero class silently.
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (&w_a_exp) & ~(|w_a_frac);
    assign w_b_inf  = (&w_b_exp) & ~(|w_b_frac);
    assign w_a_nan  = (&w_a_exp) & (|w_a_frac);
    assign w_b_nan  = (&w_b_exp) & (|w_b_frac);
    assign w_a_snan = w_a_nan & ~w_a_frac[MAN_W-1];
    assign w_b_snan = w_b_nan & ~w_b_frac[MAN_W-1];

    assign w_sign    = w_a_sign ^ w_b_sign;
    assign w_exp_sum = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - C_BIAS;

    always_comb begin
        w_spec     = 1'b0;
        w_spec_res = '0;
        w_spec_flg = 4'b0000;
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
            w_spec        = 1'b1;
            w_spec_res    = C_QNAN;
            w_spec_flg[3] = (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf) | w_a_snan | w_b_snan;
        end else if (w_a_inf | w_b_inf) begin
            w_spec     = 1'b1;
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_a_zero | w_b_zero) begin
            w_spec     = 1'b1;
            w_spec_res = {w_sign, {(EXP_W + MAN_W){1'b0}}};
        end
    end

    // ---- stage 1 register: unpacked operands, exponent sum, special select
    logic                  r_vld_p0;
    logic                  r_sign_p0;
    logic signed [EXW-1:0] r_exp_p0;
    logic [MAN_W:0]        r_ma_p0, r_mb_p0;
    logic                  r_spec_p0;
    logic [SIZE_DATA-1:0]  r_spec_res_p0;
    logic [3:0]            r_spec_flg_p0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p0      <= 1'b0;
            r_sign_p0     <= 1'b0;
            r_exp_p0      <= '0;
            r_ma_p0       <= '0;
            r_mb_p0       <= '0;
            r_spec_p0     <= 1'b0;
            r_spec_res_p0 <= '0;
            r_spec_flg_p0 <= '0;
        end else if (w_adv) begin
            r_vld_p0 <= i_valid;
            if (i_valid) begin
                r_sign_p0     <= w_sign;
                r_exp_p0      <= w_exp_sum;
                r_ma_p0       <= {1'b1, w_a_frac};
                r_mb_p0       <= {1'b1, w_b_frac};
                r_spec_p0     <= w_spec;
                r_spec_res_p0 <= w_spec_res;
                r_spec_flg_p0 <= w_spec_flg;
            end
        end
    end

    // ---- stage 2 register: full-width significand product
    logic [PW-1:0] w_prod;
    assign w_prod = PW'(r_ma_p0) * PW'(r_mb_p0);

    logic                  r_vld_p1;
    logic                  r_sign_p1;
    logic signed [EXW-1:0] r_exp_p1;
    logic [PW-1:0]         r_prod_p1;
    logic                  r_spec_p1;
    logic [SIZE_DATA-1:0]  r_spec_res_p1;
    logic [3:0]            r_spec_flg_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p1      <= 1'b0;
            r_sign_p1     <= 1'b0;
            r_exp_p1      <= '0;
            r_prod_p1     <= '0;
            r_spec_p1     <= 1'b0;
            r_spec_res_p1 <= '0;
            r_spec_flg_p1 <= '0;
        end else if (w_adv) begin
            r_vld_p1 <= r_vld_p0;
            if (r_vld_p0) begin
                r_sign_p1     <= r_sign_p0;
                r_exp_p1      <= r_exp_p0;
                r_prod_p1     <= w_prod;
                r_spec_p1     <= r_spec_p0;
                r_spec_res_p1 <= r_spec_res_p0;
                r_spec_flg_p1 <= r_spec_flg_p0;
            end
        end
    end

    // Product of two normalised significands lies in [1,4): at most one right shift.
    logic [PW-1:0]         w_norm;
    logic [MAN_W:0]        w_kept;
    logic                  w_guard, w_sticky;
    logic [MAN_W:0]        w_rnd;
    logic                  w_carry;
    logic signed [EXW-1:0] w_exp_fin;
    logic [SIZE_DATA+3:0]  w_pack;

    assign w_norm    = r_prod_p1[PW-1] ? r_prod_p1 : {r_prod_p1[PW-2:0], 1'b0};
    assign w_kept    = w_norm[PW-1 -: MAN_W+1];
    assign w_guard   = w_norm[MAN_W];
    assign w_sticky  = |w_norm[MAN_W-1:0];
    assign w_rnd     = f_rne(w_kept, w_guard, w_sticky);
    assign w_carry   = ~w_rnd[MAN_W];
    assign w_exp_fin = r_exp_p1
                     + $signed({{(EXW - 1){1'b0}}, r_prod_p1[PW-1]})
                     + $signed({{(EXW - 1){1'b0}}, w_carry});
    assign w_pack    = f_pack(r_sign_p1, w_exp_fin, w_rnd[MAN_W-1:0], w_guard | w_sticky);

    // ---- stage 3 register: packed result and flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_32_mul <= '0;
            o_flags  <= '0;
        end else if (w_adv) begin
            o_valid <= r_vld_p1;
            if (r_vld_p1) begin
                o_32_mul <= r_spec_p1 ? r_spec_res_p1 : w_pack[SIZE_DATA-1:0];
                o_flags  <= r_spec_p1 ? r_spec_flg_p1 : w_pack[SIZE_DATA+3:SIZE_DATA];
            end
        end
    end

endmodule

// File: tb/tb_fpu_mul_pipe.sv
// Directed-vector bench for fpu_mul_pipe: table of FP32 products, backpressure and mid-stream reset.
module tb_fpu_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_32_mul;
    logic [3:0]  o_flags;

    always #5 clk = ~clk;

    fpu_mul_pipe dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_32_a   (a),
        .i_32_b   (b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_32_mul (o_32_mul),
        .o_flags  (o_flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          cyc;
    } exp_t;

    vec_t        vecs[$];
    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    logic [31:0] exp_res = '0;
    logic [3:0]  exp_flg = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_res = '0;
    logic [3:0]  prev_flg = '0;
    int          stall_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Accepted pairs enter the scoreboard with their acceptance cycle.
    always @(posedge clk) begin
        if (rst_n && i_valid && o_ready)
            q.push_back(exp_t'{exp_res, exp_flg, cyc});
        cyc++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("o_ready", 64'(o_ready), 64'(!(o_valid && !i_ready)));
            if (prev_stall) begin
                stall_cnt++;
                chk("hold_valid", 64'(o_valid), 64'(1));
                chk("hold_data", 64'({o_flags, o_32_mul}), 64'({prev_flg, prev_res}));
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected no result", o_32_mul);
                end else begin
                    e = q.pop_front();
                    chk("result", 64'(o_32_mul), 64'(e.res));
                    chk("flags", 64'(o_flags), 64'(e.flg));
                    if (lat_chk)
                        chk("latency", 64'(cyc - e.cyc), 64'(3));
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_res   = o_32_mul;
            prev_flg   = o_flags;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] er, input logic [3:0] ef);
        bit ok;
        ok      = 1'b0;
        a       = ta;
        b       = tb_v;
        exp_res = er;
        exp_flg = ef;
        i_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got o_ready=0 for 50 cycles, expected acceptance");
        end
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && q.size() != 0; n++)
            @(posedge clk);
        chk("drain_pending", 64'(q.size()), 64'(0));
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(vec_t'{32'h40400000, 32'h40000000, 32'h40C00000, 4'h0});
        vecs.push_back(vec_t'{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0});
        vecs.push_back(vec_t'{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1});
        vecs.push_back(vec_t'{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'h1});
        vecs.push_back(vec_t'{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h5});
        vecs.push_back(vec_t'{32'h00800000, 32'h3F000000, 32'h00000000, 4'h3});
        vecs.push_back(vec_t'{32'h80800000, 32'h3F000000, 32'h80000000, 4'h3});
        vecs.push_back(vec_t'{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8});
        vecs.push_back(vec_t'{32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0});
        vecs.push_back(vec_t'{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0});
        vecs.push_back(vec_t'{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8});
        vecs.push_back(vec_t'{32'h00000001, 32'h40000000, 32'h00000000, 4'h0});
        vecs.push_back(vec_t'{32'hC0400000, 32'h40000000, 32'hC0C00000, 4'h0});
        // ties: odd lsb rounds up, even lsb stays
        vecs.push_back(vec_t'{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1});
        vecs.push_back(vec_t'{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1});
        // rounding carry to 1.0 bumps the exponent
        vecs.push_back(vec_t'{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'h1});
        vecs.push_back(vec_t'{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'h0});
        vecs.push_back(vec_t'{32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 4'h5});
        vecs.push_back(vec_t'{32'h00800000, 32'h3F800000, 32'h00800000, 4'h0});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 64'(o_valid), 64'(0));
        chk("rst_o_32_mul", 64'(o_32_mul), 64'(0));
        chk("rst_o_flags", 64'(o_flags), 64'(0));
        chk("rst_o_ready", 64'(o_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat_chk = 1'b1;
        foreach (vecs[i])
            send(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg);
        i_valid = 1'b0;
        drain();
        lat_chk = 1'b0;

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg);
                i_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        drain();
        chk("stall_cycles_seen", 64'(stall_cnt >= 3), 64'(1));

        send(vecs[0].a, vecs[0].b, vecs[0].res, vecs[0].flg);
        send(vecs[1].a, vecs[1].b, vecs[1].res, vecs[1].flg);
        send(vecs[2].a, vecs[2].b, vecs[2].res, vecs[2].flg);
        i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_o_valid", 64'(o_valid), 64'(0));
        chk("async_rst_o_32_mul", 64'(o_32_mul), 64'(0));
        chk("async_rst_o_flags", 64'(o_flags), 64'(0));
        q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("no_stale_output", 64'(o_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(vecs[3].a, vecs[3].b, vecs[3].res, vecs[3].flg);
        i_valid = 1'b0;
        drain();
        lat_chk = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
